// File: rtl/mac_rx_stream_out_pkg.sv
// Shared definitions for the MAC receive stream drain stage:
// frame-length width, default length limit, FSM encodings and the buffer beat.
package mac_rx_stream_out_pkg;

    localparam int LEN_W       = 11;
    localparam int MAX_LEN_DEF = 1500;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CHECK    = 3'd1;
    localparam logic [2:0] ST_READ     = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_ACK      = 3'd4;
    localparam logic [2:0] ST_WAIT_CLR = 3'd5;
    localparam logic [2:0] ST_DROP     = 3'd6;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    function automatic logic len_ok(
        input logic [LEN_W-1:0] len,
        input logic [LEN_W-1:0] max_len
    );
        return (len != '0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/mac_rx_skid_buf.sv
// Two-entry {last,data} FIFO between the MAC read port and the byte stream.
// The head entry stays put until it is handshaken, so the output is stall-stable.
module mac_rx_skid_buf
    import mac_rx_stream_out_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [8:0] wdata,
    output logic [1:0] occ,
    output logic       valid,
    input  logic       ready,
    output logic [8:0] rdata
);

    beat_t      mem [2];
    logic       wp;
    logic       rp;
    logic [1:0] count;
    logic       pop;

    assign pop   = valid & ready;
    assign valid = (count != 2'd0);
    assign occ   = count;
    assign rdata = mem[rp];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= beat_t'(wdata);
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_rx_stream_out.sv
// Drains completed frames from the receive MAC buffer into a valid/ready byte
// stream, acks the MAC once the frame has fully left, and drops illegal lengths.
module mac_rx_stream_out
    import mac_rx_stream_out_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_received,
    input  logic [10:0]      rx_payload_len,
    input  logic [7:0]       mac_rx_data_out,
    output logic             read_en,
    output logic             frame_received_ack,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [10:0]      m_len,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    logic [2:0]       state;
    logic [LEN_W-1:0] rd_idx;
    logic             infl;
    logic             infl_last;
    logic [1:0]       occ;
    logic             pop;
    logic [2:0]       used;
    logic             credit;
    logic             is_last_rd;
    logic             drained;
    logic [8:0]       head;

    mac_rx_skid_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (infl),
        .wdata ({infl_last, mac_rx_data_out}),
        .occ   (occ),
        .valid (m_valid),
        .ready (m_ready),
        .rdata (head)
    );

    assign m_data = head[7:0];
    assign m_last = head[8];
    assign pop    = m_valid & m_ready;

    // A byte leaving this cycle frees its slot, which keeps 1 byte/clk flowing.
    assign used   = {1'b0, occ} + {2'b0, infl};
    assign credit = (used < 3'd2) || ((used == 3'd2) && pop);

    assign is_last_rd = (rd_idx == m_len - 11'd1);
    assign read_en    = (state == ST_READ) && (rd_idx < m_len) && credit;

    // Buffer is empty after this edge: lets the ack follow the last beat by 1 clk.
    assign drained = !infl && ((occ == 2'd0) || ((occ == 2'd1) && pop));

    assign frame_received_ack = (state == ST_ACK) || (state == ST_DROP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            rd_idx      <= '0;
            infl        <= 1'b0;
            infl_last   <= 1'b0;
            m_len       <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            infl <= read_en;
            if (read_en) begin
                rd_idx    <= rd_idx + 11'd1;
                infl_last <= is_last_rd;
            end
            unique case (state)
                ST_IDLE: begin
                    if (frame_received) begin
                        m_len  <= rx_payload_len;
                        rd_idx <= '0;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state <= len_ok(m_len, MAX_L) ? ST_READ : ST_DROP;
                end
                ST_READ: begin
                    if (read_en && is_last_rd) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drained) state <= ST_ACK;
                end
                ST_ACK: begin
                    frame_count <= frame_count + CNT_W'(1);
                    state       <= ST_WAIT_CLR;
                end
                ST_DROP: begin
                    drop_count <= drop_count + CNT_W'(1);
                    state      <= ST_WAIT_CLR;
                end
                ST_WAIT_CLR: begin
                    if (!frame_received) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_rx_stream_out.sv
// Bench for mac_rx_stream_out: MAC buffer model, byte scoreboard and
// table-driven frame vectors plus a mid-frame reset sequence.
module tb_mac_rx_stream_out;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             frame_received = 1'b0;
    logic [10:0]      rx_payload_len = '0;
    logic [7:0]       mac_rx_data_out;
    logic             read_en;
    logic             frame_received_ack;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready = 1'b0;
    logic [10:0]      m_len;
    logic [CNT_W-1:0] frame_count;
    logic [CNT_W-1:0] drop_count;

    always #5 clk = ~clk;

    mac_rx_stream_out #(.MAX_LEN(1500), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .frame_received     (frame_received),
        .rx_payload_len     (rx_payload_len),
        .mac_rx_data_out    (mac_rx_data_out),
        .read_en            (read_en),
        .frame_received_ack (frame_received_ack),
        .m_data             (m_data),
        .m_valid            (m_valid),
        .m_last             (m_last),
        .m_ready            (m_ready),
        .m_len              (m_len),
        .frame_count        (frame_count),
        .drop_count         (drop_count)
    );

    typedef struct {
        int         len;
        int         mode;
        int         hold;
        logic [7:0] b0;
        logic [7:0] step;
        logic       exp_drop;
        int         exp_beats;
    } vec_t;

    logic [7:0]  pay [0:2047];
    logic [10:0] rptr;
    logic [8:0]  exp_q [$];
    int cyc = 0;
    int rd_cnt, acc_cnt, ack_cnt;
    int beats, max_out, stall_err, last_cyc;
    int ready_mode = 0;
    int rcyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    logic       p_stall = 1'b0;
    logic       pl;
    logic [7:0] pd;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // MAC payload buffer: byte appears 1 clk after read_en, pointer rewinds on ack
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr            <= '0;
            mac_rx_data_out <= '0;
        end else begin
            if (read_en) begin
                mac_rx_data_out <= pay[rptr];
                rptr            <= rptr + 11'd1;
            end
            if (frame_received_ack) rptr <= '0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt  <= 0;
            acc_cnt <= 0;
            ack_cnt <= 0;
        end else begin
            if (read_en) rd_cnt <= rd_cnt + 1;
            if (m_valid && m_ready) acc_cnt <= acc_cnt + 1;
            if (frame_received_ack) ack_cnt <= ack_cnt + 1;
        end
    end

    always @(posedge clk) begin
        #2;
        rcyc++;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = (rcyc % 3 == 0);
            default: m_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            if (rd_cnt - acc_cnt > max_out) max_out = rd_cnt - acc_cnt;
            if (p_stall && (!m_valid || m_data !== pd || m_last !== pl))
                stall_err++;
            p_stall = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
            if (m_valid && m_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat_extra got %h expected none",
                             {m_last, m_data});
                end else begin
                    chk("beat", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
                end
                if (m_last) last_cyc = cyc;
            end
        end else begin
            p_stall = 1'b0;
        end
    end

    task automatic run_frame(input vec_t v);
        logic [CNT_W-1:0] fc, dc;
        int r0, a0, ack_at;
        logic got;
        fc = frame_count;
        dc = drop_count;
        r0 = rd_cnt;
        a0 = ack_cnt;
        beats = 0;
        max_out = 0;
        stall_err = 0;
        ready_mode = v.mode;
        for (int i = 0; i < v.len && i < 2048; i++)
            pay[i] = 8'(v.b0 + v.step * i);
        if (!v.exp_drop)
            for (int i = 0; i < v.len; i++)
                exp_q.push_back({(i == v.len - 1), pay[i]});
        @(negedge clk);
        rx_payload_len = 11'(v.len);
        frame_received = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 5000 && !got; k++) begin
            @(negedge clk);
            if (frame_received_ack) got = 1'b1;
        end
        ack_at = cyc;
        chk("ack_seen", 32'(got), 32'd1);
        if (got && !v.exp_drop)
            chk("ack_after_last", 32'(ack_at - last_cyc), 32'd1);
        chk("m_len", 32'(m_len), 32'(v.len));
        repeat (v.hold) @(negedge clk);
        frame_received = 1'b0;
        repeat (4) @(negedge clk);
        chk("beats", 32'(beats), 32'(v.exp_beats));
        chk("reads", 32'(rd_cnt - r0), 32'(v.exp_beats));
        chk("ack_once", 32'(ack_cnt - a0), 32'd1);
        chk("frame_inc", 32'(CNT_W'(frame_count - fc)), 32'(!v.exp_drop));
        chk("drop_inc", 32'(CNT_W'(drop_count - dc)), 32'(v.exp_drop));
        chk("credit", 32'(max_out <= 2), 32'd1);
        chk("stall_stable", 32'(stall_err), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs [8];
    vec_t vr;

    initial begin
        vecs[0] = '{4,    0, 0, 8'h11, 8'h11, 1'b0, 4};
        vecs[1] = '{8,    1, 0, 8'h80, 8'h03, 1'b0, 8};
        vecs[2] = '{0,    0, 0, 8'h00, 8'h00, 1'b1, 0};
        vecs[3] = '{1501, 0, 0, 8'h00, 8'h01, 1'b1, 0};
        vecs[4] = '{1,    0, 0, 8'hA5, 8'h00, 1'b0, 1};
        vecs[5] = '{1500, 0, 0, 8'h00, 8'h01, 1'b0, 1500};
        vecs[6] = '{0,    0, 3, 8'h00, 8'h00, 1'b1, 0};
        vecs[7] = '{5,    1, 0, 8'h5A, 8'h11, 1'b0, 5};
        vr      = '{3,    0, 0, 8'hC0, 8'h07, 1'b0, 3};

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({read_en, frame_received_ack, m_valid, m_last, m_data, m_len}),
            32'd0);
        chk("reset_counters", {frame_count, drop_count}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int n = 0; n < 8; n++) run_frame(vecs[n]);
        chk("frame_total", 32'(frame_count), 32'd5);
        chk("drop_total", 32'(drop_count), 32'd3);

        // Reset while the third byte of a 10-byte frame is being read
        ready_mode = 0;
        for (int i = 0; i < 10; i++) pay[i] = 8'(8'h30 + i);
        for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), pay[i]});
        @(negedge clk);
        rx_payload_len = 11'd10;
        frame_received = 1'b1;
        begin
            int k;
            k = 0;
            while (rd_cnt < 3 && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk("reset_reach_read", 32'(rd_cnt >= 3), 32'd1);
        end
        rst = 1'b0;
        frame_received = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_outputs",
            32'({read_en, frame_received_ack, m_valid, m_last, m_data, m_len}),
            32'd0);
        @(posedge clk);
        #1;
        chk("midrst_edge",
            32'({read_en, frame_received_ack, m_valid, m_last, m_data, m_len}),
            32'd0);
        chk("midrst_counters", {frame_count, drop_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_ack", 32'(ack_cnt), 32'd0);
        chk("midrst_idle", 32'({read_en, m_valid}), 32'd0);
        run_frame(vr);
        chk("post_reset_frames", 32'(frame_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
